// File: rtl/rq_unpack_pkg.sv
// rq_unpack_pkg: shared types and lane geometry for the Rq byte unpack path
package rq_unpack_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EMIT} seq_state_t;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
endpackage

// File: rtl/mux_4i8_o1.sv
// mux_4i8_o1: 4-input byte mux, sel=0 picks i0 (the low byte of a packed word)
module mux_4i8_o1
  import rq_unpack_pkg::*;
(
  input  logic [LANE_W-1:0] i3,
  input  logic [LANE_W-1:0] i2,
  input  logic [LANE_W-1:0] i1,
  input  logic [LANE_W-1:0] i0,
  input  logic [1:0]        sel,
  output logic [LANE_W-1:0] o
);
  always_comb o = sel == 2'd3 ? i3 : sel == 2'd2 ? i2 : sel == 2'd1 ? i1 : i0;
endmodule

// File: rtl/rq_byte_lane_sequencer.sv
// rq_byte_lane_sequencer: serialises 32-bit packed words into a LEN-byte frame, lane 0 first
module rq_byte_lane_sequencer
  import rq_unpack_pkg::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic [1:0]       lane_sel
);
  seq_state_t       state, state_nx;
  logic [31:0]      hold;
  logic [LEN_W-1:0] remaining;
  logic             fire, final_byte, last_lane;
  assign fire       = state == ST_EMIT && byte_ready;
  assign final_byte = remaining == LEN_W'(1);
  assign last_lane  = lane_sel == 2'(LANES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = state == ST_IDLE ? ((start && len != '0) ? ST_LOAD : ST_IDLE) :
               state == ST_LOAD ? (word_valid ? ST_EMIT : ST_LOAD) :
               state == ST_EMIT ? (!fire ? ST_EMIT : final_byte ? ST_IDLE :
                                   last_lane ? ST_LOAD : ST_EMIT) :
               ST_IDLE;
  always_comb begin
    busy       = state != ST_IDLE;
    word_ready = state == ST_LOAD;
    byte_valid = state == ST_EMIT;
    byte_last  = state == ST_EMIT && final_byte;
  end
  // Partial final words need no special case: the exit at remaining==1 drops the upper lanes.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold      <= '0;
      lane_sel  <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == ST_IDLE && start && len == '0) || (fire && final_byte);
      if (state == ST_IDLE && start && len != '0) begin
        remaining <= len;
        lane_sel  <= '0;
      end
      if (state == ST_LOAD && word_valid) begin
        hold     <= word_in;
        lane_sel <= '0;
      end
      if (fire) begin
        remaining <= remaining - LEN_W'(1);
        if (!final_byte && !last_lane) lane_sel <= lane_sel + 2'd1;
      end
    end
  mux_4i8_o1 u_mux (
    .i3 (hold[31:24]),
    .i2 (hold[23:16]),
    .i1 (hold[15:8]),
    .i0 (hold[7:0]),
    .sel(lane_sel),
    .o  (byte_out)
  );
endmodule
